// File: rtl/term_char_buffer_pkg.sv
// Shared constants and types for the terminal character buffer.
package term_pkg;

   // Control and printable-range byte values understood by the terminal.
   localparam logic [7:0] CH_BS       = 8'h08;
   localparam logic [7:0] CH_LF       = 8'h0A;
   localparam logic [7:0] CH_FF       = 8'h0C;
   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_SPACE    = 8'h20;
   localparam logic [7:0] CH_DEL      = 8'h7F;
   localparam logic [7:0] CH_PRINT_LO = 8'h20;
   localparam logic [7:0] CH_PRINT_HI = 8'h7E;

   // Sweep states: full-screen clear, normal byte handling, one-row clear.
   typedef enum logic [1:0] {
      S_CLEAR,
      S_IDLE,
      S_SCROLL
   } state_e;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
   endfunction

endpackage

// File: rtl/term_char_buffer_char_ram_dp.sv
// Simple dual-port character RAM: one write port, one registered read port.
module char_ram_dp #(
   parameter int DEPTH  = 2400,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);

   // NOTE: the array has no reset so it maps onto block RAM; contents are
   // initialised by the owner's clear sweep instead.
   logic [7:0] mem_q [DEPTH];

   // Write port.
   // NOTE: non-blocking assignments here also make a same-address read in
   // the same cycle return the old contents.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // Registered read port, one cycle of latency.
   always_ff @(posedge clk) begin
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/term_char_buffer.sv
// Terminal text buffer: interprets UART bytes, keeps the cursor and a
// circularly scrolled screen in character RAM, and serves renderer reads.
module term_char_buffer
   import term_pkg::*;
#(
   parameter int         COLS       = 80,
   parameter int         ROWS       = 30,
   parameter logic [7:0] CLEAR_CHAR = CH_SPACE,
   localparam int        COL_W      = $clog2(COLS),
   localparam int        ROW_W      = $clog2(ROWS),
   localparam int        ADDR_W     = $clog2(COLS*ROWS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             busy,
   output logic [7:0]       drop_cnt,
   input  logic [ROW_W-1:0] rd_row,
   input  logic [COL_W-1:0] rd_col,
   output logic [7:0]       rd_data,
   output logic [ROW_W-1:0] cur_row,
   output logic [COL_W-1:0] cur_col
);

   state_e             state_q,      state_d;
   logic [ADDR_W-1:0]  sweep_q,      sweep_d;
   logic [ROW_W-1:0]   scroll_row_q, scroll_row_d;
   logic [ROW_W-1:0]   top_row_q,    top_row_d;
   logic [ROW_W-1:0]   cur_row_q,    cur_row_d;
   logic [COL_W-1:0]   cur_col_q,    cur_col_d;
   logic               hold_full_q,  hold_full_d;
   logic [7:0]         hold_data_q,  hold_data_d;
   logic [7:0]         drop_q,       drop_d;

   logic               we;
   logic [ADDR_W-1:0]  waddr;
   logic [7:0]         wdata;
   logic               consume;
   logic               newline;
   logic [ROW_W-1:0]   cur_phys;
   logic [ADDR_W-1:0]  raddr;

   // Screen row to physical RAM row, wrapping around the circular buffer.
   function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] row,
                                                 input logic [ROW_W-1:0] top);
      logic [ROW_W:0] sum;
      sum = {1'b0, row} + {1'b0, top};
      if (sum >= (ROW_W+1)'(ROWS)) sum = sum - (ROW_W+1)'(ROWS);
      return sum[ROW_W-1:0];
   endfunction

   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
      return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
   endfunction

   assign cur_phys = phys_row(cur_row_q, top_row_q);
   assign raddr    = cell_addr(phys_row(rd_row, top_row_q), rd_col);

   // Next-state logic: sweeps, byte interpretation and the input hold register.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d      = state_q;
      sweep_d      = sweep_q;
      scroll_row_d = scroll_row_q;
      top_row_d    = top_row_q;
      cur_row_d    = cur_row_q;
      cur_col_d    = cur_col_q;
      hold_full_d  = hold_full_q;
      hold_data_d  = hold_data_q;
      drop_d       = drop_q;
      we           = 1'b0;
      waddr        = cell_addr(cur_phys, cur_col_q);
      wdata        = CLEAR_CHAR;
      consume      = 1'b0;
      newline      = 1'b0;

      case (state_q)
         S_CLEAR: begin
            we    = 1'b1;
            waddr = sweep_q;
            if (sweep_q == ADDR_W'(COLS*ROWS-1)) begin
               state_d = S_IDLE;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + 1'b1;
            end
         end
         S_SCROLL: begin
            we    = 1'b1;
            waddr = cell_addr(scroll_row_q, sweep_q[COL_W-1:0]);
            if (sweep_q == ADDR_W'(COLS-1)) begin
               state_d = S_IDLE;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (hold_full_q) begin
               consume = 1'b1;
               if (is_printable(hold_data_q)) begin
                  we    = 1'b1;
                  wdata = hold_data_q;
                  if (cur_col_q < COL_W'(COLS-1)) cur_col_d = cur_col_q + 1'b1;
                  else                            newline   = 1'b1;
               end else begin
                  case (hold_data_q)
                     CH_CR: cur_col_d = '0;
                     CH_LF: newline   = 1'b1;
                     CH_BS, CH_DEL: begin
                        if (cur_col_q != '0) begin
                           cur_col_d = cur_col_q - 1'b1;
                           we        = 1'b1;
                           waddr     = cell_addr(cur_phys, cur_col_q - 1'b1);
                        end
                     end
                     CH_FF: begin
                        cur_row_d = '0;
                        cur_col_d = '0;
                        top_row_d = '0;
                        sweep_d   = '0;
                        state_d   = S_CLEAR;
                     end
                     default: ;
                  endcase
               end
               if (newline) begin
                  cur_col_d = '0;
                  if (cur_row_q < ROW_W'(ROWS-1)) begin
                     cur_row_d = cur_row_q + 1'b1;
                  end else begin
                     // The old top row becomes the new bottom row; blank it.
                     scroll_row_d = top_row_q;
                     top_row_d    = (top_row_q == ROW_W'(ROWS-1)) ? '0 : top_row_q + 1'b1;
                     sweep_d      = '0;
                     state_d      = S_SCROLL;
                  end
               end
            end
         end
         default: begin
            state_d = S_CLEAR;
            sweep_d = '0;
         end
      endcase

      // A byte may enter whenever the slot is free or is being emptied now.
      if (in_valid && (!hold_full_q || consume)) begin
         hold_full_d = 1'b1;
         hold_data_d = in_data;
      end else begin
         if (consume) hold_full_d = 1'b0;
         if (in_valid && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
   end

   // State registers with synchronous reset; reset always restarts a full clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_CLEAR;
         sweep_q      <= '0;
         scroll_row_q <= '0;
         top_row_q    <= '0;
         cur_row_q    <= '0;
         cur_col_q    <= '0;
         hold_full_q  <= 1'b0;
         hold_data_q  <= '0;
         drop_q       <= '0;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         scroll_row_q <= scroll_row_d;
         top_row_q    <= top_row_d;
         cur_row_q    <= cur_row_d;
         cur_col_q    <= cur_col_d;
         hold_full_q  <= hold_full_d;
         hold_data_q  <= hold_data_d;
         drop_q       <= drop_d;
      end
   end

   char_ram_dp #(
      .DEPTH  (COLS*ROWS),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (we & rst_n),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (raddr),
      .rdata_o (rd_data)
   );

   assign busy     = (state_q != S_IDLE);
   assign drop_cnt = drop_q;
   assign cur_row  = cur_row_q;
   assign cur_col  = cur_col_q;

endmodule

// File: tb/tb_term_char_buffer.sv
// Randomised scoreboard bench for term_char_buffer against a visible-screen model.
module tb_term_char_buffer;

   localparam int         COLS = 80;
   localparam int         ROWS = 30;
   localparam logic [7:0] SP   = 8'h20;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic [7:0] in_data  = 8'h00;
   logic       in_valid = 1'b0;
   logic       busy;
   logic [7:0] drop_cnt;
   logic [4:0] rd_row   = '0;
   logic [6:0] rd_col   = '0;
   logic [7:0] rd_data;
   logic [4:0] cur_row;
   logic [6:0] cur_col;

   always #5 clk = ~clk;

   term_char_buffer #(.COLS(COLS), .ROWS(ROWS), .CLEAR_CHAR(SP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .busy     (busy),
      .drop_cnt (drop_cnt),
      .rd_row   (rd_row),
      .rd_col   (rd_col),
      .rd_data  (rd_data),
      .cur_row  (cur_row),
      .cur_col  (cur_col)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         row;
      int         col;
      logic [7:0] data;
   } rd_exp_t;

   rd_exp_t    exp_q[$];
   logic       rd_req   = 1'b0;
   logic       rd_req_d = 1'b0;

   // Reference model: the visible screen, row 0 at the top; scrolling shifts rows.
   logic [7:0] scr [ROWS][COLS];
   int         m_row;
   int         m_col;
   int         exp_drop;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) scr[r][c] = SP;
      m_row = 0;
      m_col = 0;
   endtask

   task automatic model_newline(output int eb);
      eb    = 0;
      m_col = 0;
      if (m_row < ROWS-1) begin
         m_row++;
      end else begin
         for (int r = 0; r < ROWS-1; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
         for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = SP;
         eb = COLS;
      end
   endtask

   // Applies one byte to the model; eb = expected busy cycles it triggers.
   task automatic model_byte(input logic [7:0] b, output int eb);
      eb = 0;
      if (b >= 8'h20 && b <= 8'h7E) begin
         scr[m_row][m_col] = b;
         if (m_col < COLS-1) m_col++;
         else                model_newline(eb);
      end else begin
         case (b)
            8'h0D: m_col = 0;
            8'h0A: model_newline(eb);
            8'h08, 8'h7F: begin
               if (m_col > 0) begin
                  m_col--;
                  scr[m_row][m_col] = SP;
               end
            end
            8'h0C: begin
               model_reset();
               eb = COLS*ROWS;
            end
            default: ;
         endcase
      end
   endtask

   // Monitor: rd_data is due one cycle after a requested address was sampled.
   always @(posedge clk) rd_req_d <= rd_req;

   always @(negedge clk) begin
      rd_exp_t e;
      if (rd_req_d) begin
         if (exp_q.size() == 0) begin
            check("rd_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("rd(%0d,%0d)", e.row, e.col), rd_data, e.data);
         end
      end
   end

   task automatic read_cell(input int r, input int c);
      rd_row = 5'(r);
      rd_col = 7'(c);
      rd_req = 1'b1;
      exp_q.push_back('{r, c, scr[r][c]});
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic check_screen();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) read_cell(r, c);
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      int eb;
      n        = 0;
      in_data  = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      model_byte(b, eb);
      while (busy && n < 5000) begin
         n++;
         @(negedge clk);
      end
      check($sformatf("busy_len(0x%02h)", b), n, eb);
      check("cur_row", cur_row, m_row);
      check("cur_col", cur_col, m_col);
   endtask

   task automatic reset_and_clear();
      int n;
      n        = 0;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      while (busy && n < 5000) begin
         n++;
         @(negedge clk);
      end
      check("reset_busy_len", n, COLS*ROWS);
      model_reset();
      exp_drop = 0;
      check("reset_cur_row", cur_row, 0);
      check("reset_cur_col", cur_col, 0);
      check("reset_drop_cnt", drop_cnt, exp_drop);
   endtask

   function automatic logic [7:0] rand_byte();
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 60) return 8'($urandom_range(32, 126));
      if (sel < 70) return 8'h0A;
      if (sel < 76) return 8'h0D;
      if (sel < 82) return 8'h08;
      if (sel < 86) return 8'h7F;
      if (sel < 87) return 8'h0C;
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int eb;

      // Reset clear and an all-blank screen.
      reset_and_clear();
      check_screen();

      // Two printables, then a full row with wrap, then backspace edge cases.
      send_byte(8'h41);
      send_byte(8'h42);
      read_cell(0, 0);
      read_cell(0, 1);
      read_cell(0, 2);
      send_byte(8'h0D);
      for (int i = 0; i < COLS; i++) send_byte(8'h58);
      for (int c = 0; c < COLS; c++) read_cell(0, c);
      send_byte(8'h08);
      send_byte(8'h43);
      send_byte(8'h08);
      read_cell(1, 0);

      // Form feed, then scroll the first line off the top.
      send_byte(8'h0C);
      send_byte(8'h5A);
      for (int i = 0; i < ROWS; i++) send_byte(8'h0A);
      check_screen();

      // Three strobes while a form-feed clear runs: one kept, two dropped.
      in_data  = 8'h0C;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      model_byte(8'h0C, eb);
      n = 0;
      while (busy && n < 5000) begin
         if (n < 3) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h61 + n);
         end else begin
            in_valid = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("ff_busy_len", n, eb);
      repeat (2) @(negedge clk);
      model_byte(8'h61, eb);
      exp_drop = 2;
      check("drop_cnt", drop_cnt, exp_drop);
      check("drop_cur_row", cur_row, m_row);
      check("drop_cur_col", cur_col, m_col);
      read_cell(0, 0);
      read_cell(0, 1);

      // Random terminal traffic with spot reads.
      for (int i = 0; i < 400; i++) begin
         send_byte(rand_byte());
         if (i % 50 == 49)
            for (int k = 0; k < 20; k++)
               read_cell($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
      end
      @(negedge clk);
      check("drop_after_random", drop_cnt, exp_drop);
      check_screen();

      // Reset in the middle of a scroll sweep.
      while (m_row < ROWS-1) send_byte(8'h0A);
      in_data  = 8'h0A;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      check("scroll_started", busy, 1);
      repeat (10) @(negedge clk);
      reset_and_clear();
      send_byte(8'h51);
      check_screen();

      repeat (3) @(negedge clk);
      check("rd_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
